// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared types for the calculator sequencer slice.
//   state_t  : controller states, 3-bit encoding (also exported as state_o)
//   action_t : one decoded user action per NES frame
// -----------------------------------------------------------------------------
package calc_pkg;

    typedef enum logic [2:0] {
        ST_ENTER_A   = 3'd0,
        ST_ENTER_B   = 3'd1,
        ST_CHOOSE_OP = 3'd2,
        ST_CALC      = 3'd3,
        ST_SHOW      = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE   = 3'd0,
        ACT_UP     = 3'd1,
        ACT_DOWN   = 3'd2,
        ACT_LEFT   = 3'd3,
        ACT_RIGHT  = 3'd4,
        ACT_SELECT = 3'd5,
        ACT_A      = 3'd6,
        ACT_B      = 3'd7
    } action_t;

endpackage

// File: rtl/nes_btn_edge.sv
// -----------------------------------------------------------------------------
// nes_btn_edge
// Turns raw NES button frames into at most one action per frame.
//   i_clk, i_reset_n      : clock, synchronous active-low reset
//   i_btn_valid           : one-cycle strobe, a new frame is on the button pins
//   i_up .. i_b_but       : decoded buttons, active-high
//   o_action              : highest-priority action of this frame (combinational)
//   o_act_valid           : high when o_action is meaningful this cycle
// Up/down auto-repeat: a held button fires again on frame REPEAT_FRAMES and on
// every frame after that, until released.
// -----------------------------------------------------------------------------
module nes_btn_edge
    import calc_pkg::*;
#(
    parameter int REPEAT_FRAMES = 30
) (
    input  logic    i_clk,
    input  logic    i_reset_n,
    input  logic    i_btn_valid,
    input  logic    i_up,
    input  logic    i_down,
    input  logic    i_left,
    input  logic    i_right,
    input  logic    i_select,
    input  logic    i_a_but,
    input  logic    i_b_but,
    output action_t o_action,
    output logic    o_act_valid
);

    localparam int CW = $clog2(REPEAT_FRAMES + 1);
    // A counter value of N means the button has already been held for N frames,
    // so the current frame is frame N+1.  Saturating at REPEAT_FRAMES-1 keeps
    // every later frame in the repeat window.
    localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_FRAMES - 1);

    logic [6:0]    w_btn;
    logic [6:0]    w_press;
    logic [6:0]    r_prev;
    logic [CW-1:0] r_upCnt;
    logic [CW-1:0] r_dnCnt;
    logic          w_upRep;
    logic          w_dnRep;

    assign w_btn   = {i_a_but, i_b_but, i_up, i_down, i_left, i_right, i_select};
    assign w_press = w_btn & ~r_prev;
    assign w_upRep = i_up   && (r_upCnt == REP_LAST);
    assign w_dnRep = i_down && (r_dnCnt == REP_LAST);

    // Previous-frame image and hold counters advance only when a frame arrives,
    // so idle cycles between frames never count as releases.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_prev  <= '0;
            r_upCnt <= '0;
            r_dnCnt <= '0;
        end else if (i_btn_valid) begin
            r_prev <= w_btn;
            if (!i_up)
                r_upCnt <= '0;
            else if (r_upCnt != REP_LAST)
                r_upCnt <= r_upCnt + CW'(1);
            if (!i_down)
                r_dnCnt <= '0;
            else if (r_dnCnt != REP_LAST)
                r_dnCnt <= r_dnCnt + CW'(1);
        end
    end

    // Fixed priority: A > B > up > down > left > right > select.
    always_comb begin
        o_action = ACT_NONE;
        if (w_press[6])
            o_action = ACT_A;
        else if (w_press[5])
            o_action = ACT_B;
        else if (w_press[4] || w_upRep)
            o_action = ACT_UP;
        else if (w_press[3] || w_dnRep)
            o_action = ACT_DOWN;
        else if (w_press[2])
            o_action = ACT_LEFT;
        else if (w_press[1])
            o_action = ACT_RIGHT;
        else if (w_press[0])
            o_action = ACT_SELECT;
    end

    assign o_act_valid = i_btn_valid && (o_action != ACT_NONE);

endmodule

// File: rtl/calc_sequencer.sv
// -----------------------------------------------------------------------------
// calc_sequencer
// Sequences a calculator session over an external add_sub / mux2 / sevenseg
// datapath from NES pad frames.
//   clk, reset_n           : clock, synchronous active-low reset
//   btn_valid, buttons     : NES frame strobe and decoded buttons
//   sum, diff, cout        : datapath results (WIDTH+1 bits) and adder carry
//   op_a, op_b, cin        : operands and carry-in to add_sub
//   sel_sub                : 0 = show sum, 1 = show diff
//   disp_val, led          : seven-segment value and overflow/borrow LED
//   state_o                : current state encoding
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SETTLE        = 2,
    parameter int REPEAT_FRAMES = 30
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             btn_valid,
    input  logic             up,
    input  logic             down,
    input  logic             left,
    input  logic             right,
    input  logic             select,
    input  logic             a_but,
    input  logic             b_but,
    input  logic [WIDTH:0]   sum,
    input  logic [WIDTH:0]   diff,
    input  logic             cout,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             cin,
    output logic             sel_sub,
    output logic [WIDTH:0]   disp_val,
    output logic             led,
    output logic [2:0]       state_o
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    action_t          w_action;
    logic             w_actValid;
    action_t          w_act;

    state_t           r_state,    w_nextState;
    logic [WIDTH-1:0] r_opA,      w_nextOpA;
    logic [WIDTH-1:0] r_opB,      w_nextOpB;
    logic             r_cin,      w_nextCin;
    logic             r_selSub,   w_nextSelSub;
    logic [WIDTH:0]   r_disp,     w_nextDisp;
    logic             r_led,      w_nextLed;
    logic [SW-1:0]    r_settle,   w_nextSettle;

    nes_btn_edge #(
        .REPEAT_FRAMES (REPEAT_FRAMES)
    ) u_btnEdge (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_btn_valid (btn_valid),
        .i_up        (up),
        .i_down      (down),
        .i_left      (left),
        .i_right     (right),
        .i_select    (select),
        .i_a_but     (a_but),
        .i_b_but     (b_but),
        .o_action    (w_action),
        .o_act_valid (w_actValid)
    );

    assign w_act = w_actValid ? w_action : ACT_NONE;

    // State and every output register share one synchronous reset, so a reset
    // in the middle of CALC simply drops the pending latch.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_ENTER_A;
            r_opA    <= '0;
            r_opB    <= '0;
            r_cin    <= 1'b0;
            r_selSub <= 1'b0;
            r_disp   <= '0;
            r_led    <= 1'b0;
            r_settle <= '0;
        end else begin
            r_state  <= w_nextState;
            r_opA    <= w_nextOpA;
            r_opB    <= w_nextOpB;
            r_cin    <= w_nextCin;
            r_selSub <= w_nextSelSub;
            r_disp   <= w_nextDisp;
            r_led    <= w_nextLed;
            r_settle <= w_nextSettle;
        end
    end

    // Next-state and next-register logic.  CALC ignores actions entirely,
    // which keeps the operands and selects frozen while the adder settles.
    // The settle counter runs only inside CALC and is zero everywhere else.
    always_comb begin
        w_nextState  = r_state;
        w_nextOpA    = r_opA;
        w_nextOpB    = r_opB;
        w_nextCin    = r_cin;
        w_nextSelSub = r_selSub;
        w_nextDisp   = r_disp;
        w_nextLed    = r_led;
        w_nextSettle = '0;

        case (r_state)
            ST_ENTER_A: begin
                case (w_act)
                    ACT_UP:   w_nextOpA   = r_opA + WIDTH'(1);
                    ACT_DOWN: w_nextOpA   = r_opA - WIDTH'(1);
                    ACT_A:    w_nextState = ST_ENTER_B;
                    default:  ;
                endcase
            end
            ST_ENTER_B: begin
                case (w_act)
                    ACT_UP:     w_nextOpB   = r_opB + WIDTH'(1);
                    ACT_DOWN:   w_nextOpB   = r_opB - WIDTH'(1);
                    ACT_SELECT: w_nextCin   = ~r_cin;
                    ACT_A:      w_nextState = ST_CHOOSE_OP;
                    ACT_B:      w_nextState = ST_ENTER_A;
                    default:    ;
                endcase
            end
            ST_CHOOSE_OP: begin
                case (w_act)
                    ACT_LEFT:   w_nextSelSub = 1'b0;
                    ACT_RIGHT:  w_nextSelSub = 1'b1;
                    ACT_SELECT: w_nextSelSub = ~r_selSub;
                    ACT_A:      w_nextState  = ST_CALC;
                    ACT_B:      w_nextState  = ST_ENTER_B;
                    default:    ;
                endcase
            end
            ST_CALC: begin
                if (r_settle == SETTLE_LAST) begin
                    w_nextDisp  = r_selSub ? diff : sum;
                    w_nextLed   = r_selSub ? diff[WIDTH] : cout;
                    w_nextState = ST_SHOW;
                end else begin
                    w_nextSettle = r_settle + SW'(1);
                end
            end
            ST_SHOW: begin
                case (w_act)
                    ACT_A:   w_nextState = ST_ENTER_A;
                    ACT_B:   w_nextState = ST_CHOOSE_OP;
                    default: ;
                endcase
            end
            default: w_nextState = ST_ENTER_A;
        endcase

        // In the entry states the display tracks the operand being edited,
        // including on the very cycle the state is entered.
        if (w_nextState == ST_ENTER_A)
            w_nextDisp = {1'b0, w_nextOpA};
        else if (w_nextState == ST_ENTER_B)
            w_nextDisp = {1'b0, w_nextOpB};
    end

    assign op_a     = r_opA;
    assign op_b     = r_opB;
    assign cin      = r_cin;
    assign sel_sub  = r_selSub;
    assign disp_val = r_disp;
    assign led      = r_led;
    assign state_o  = r_state;

endmodule

// File: tb/tb_calc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_sequencer
// Directed bench for calc_sequencer with WIDTH=4, SETTLE=2, REPEAT_FRAMES=30.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_calc_sequencer;

    localparam int WIDTH = 4;

    localparam logic [6:0] BA    = 7'b1000000;
    localparam logic [6:0] BB    = 7'b0100000;
    localparam logic [6:0] BUP   = 7'b0010000;
    localparam logic [6:0] BDN   = 7'b0001000;
    localparam logic [6:0] BLEFT = 7'b0000100;
    localparam logic [6:0] BRGT  = 7'b0000010;
    localparam logic [6:0] BSEL  = 7'b0000001;

    localparam int S_A    = 0;
    localparam int S_B    = 1;
    localparam int S_OP   = 2;
    localparam int S_CALC = 3;
    localparam int S_SHOW = 4;

    logic             clk;
    logic             reset_n;
    logic             btn_valid;
    logic             up, down, left, right, select, a_but, b_but;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             cout;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             sel_sub;
    logic [WIDTH:0]   disp_val;
    logic             led;
    logic [2:0]       state_o;

    int checks   = 0;
    int failures = 0;

    calc_sequencer #(
        .WIDTH         (WIDTH),
        .SETTLE        (2),
        .REPEAT_FRAMES (30)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_valid (btn_valid),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .select    (select),
        .a_but     (a_but),
        .b_but     (b_but),
        .sum       (sum),
        .diff      (diff),
        .cout      (cout),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .sel_sub   (sel_sub),
        .disp_val  (disp_val),
        .led       (led),
        .state_o   (state_o)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One frame: present buttons with btn_valid for a single rising edge.
    // Called at a falling edge, returns at the next falling edge; calling it
    // repeatedly gives btn_valid on every cycle.
    task automatic applyStimulus(input logic [6:0] b);
        {a_but, b_but, up, down, left, right, select} = b;
        btn_valid = 1'b1;
        @(negedge clk);
        btn_valid = 1'b0;
    endtask

    // Press then release.
    task automatic tapButton(input logic [6:0] b);
        applyStimulus(b);
        applyStimulus(7'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        btn_valid = 1'b0;
        {a_but, b_but, up, down, left, right, select} = 7'b0;
        sum  = '0;
        diff = '0;
        cout = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("rst_state", 32'(state_o), S_A);
        checkOutput("rst_op_a", 32'(op_a), 0);
        checkOutput("rst_disp", 32'(disp_val), 0);
        checkOutput("rst_led", 32'(led), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Increment: effect visible one cycle after the frame.
        applyStimulus(BUP);
        checkOutput("inc_latency", 32'(op_a), 1);
        applyStimulus(7'b0);
        tapButton(BUP);
        tapButton(BUP);
        checkOutput("inc_op_a", 32'(op_a), 3);
        checkOutput("inc_disp", 32'(disp_val), 3);
        checkOutput("inc_state", 32'(state_o), S_A);
        checkOutput("inc_led", 32'(led), 0);

        // Wrap boundaries.
        repeat (3) tapButton(BDN);
        tapButton(BDN);
        checkOutput("wrap_down", 32'(op_a), 15);
        tapButton(BUP);
        checkOutput("wrap_up", 32'(op_a), 0);

        // Auto-repeat with back-to-back frames: press at 1, repeats at 30..32.
        repeat (29) applyStimulus(BUP);
        checkOutput("rep_29", 32'(op_a), 1);
        applyStimulus(BUP);
        checkOutput("rep_30", 32'(op_a), 2);
        repeat (2) applyStimulus(BUP);
        checkOutput("rep_32", 32'(op_a), 4);
        applyStimulus(7'b0);

        // Addition with carry: 9 + 8.
        repeat (5) tapButton(BUP);
        checkOutput("add_op_a", 32'(op_a), 9);
        tapButton(BA);
        checkOutput("add_state_b", 32'(state_o), S_B);
        checkOutput("add_disp_b0", 32'(disp_val), 0);
        repeat (8) tapButton(BUP);
        checkOutput("add_op_b", 32'(op_b), 8);
        checkOutput("add_disp_b", 32'(disp_val), 8);
        tapButton(BA);
        checkOutput("add_state_op", 32'(state_o), S_OP);
        checkOutput("add_disp_hold", 32'(disp_val), 8);
        tapButton(BSEL);
        checkOutput("op_sel_toggle", 32'(sel_sub), 1);
        tapButton(BLEFT);
        checkOutput("op_left", 32'(sel_sub), 0);
        sum  = 5'd17;
        cout = 1'b1;
        diff = 5'd1;
        applyStimulus(BA);
        checkOutput("add_calc_n", 32'(state_o), S_CALC);
        applyStimulus(BUP | BB);
        checkOutput("add_calc_n1", 32'(state_o), S_CALC);
        checkOutput("calc_iso_a", 32'(op_a), 9);
        checkOutput("calc_iso_b", 32'(op_b), 8);
        applyStimulus(7'b0);
        checkOutput("add_show", 32'(state_o), S_SHOW);
        checkOutput("add_disp", 32'(disp_val), 17);
        checkOutput("add_led", 32'(led), 1);

        // Subtraction with borrow: 2 - 5.
        tapButton(BA);
        checkOutput("show_to_a", 32'(state_o), S_A);
        checkOutput("show_disp_a", 32'(disp_val), 9);
        repeat (7) tapButton(BDN);
        tapButton(BA);
        repeat (3) tapButton(BDN);
        checkOutput("sub_op_a", 32'(op_a), 2);
        checkOutput("sub_op_b", 32'(op_b), 5);
        tapButton(BSEL);
        checkOutput("cin_on", 32'(cin), 1);
        tapButton(BSEL);
        checkOutput("cin_off", 32'(cin), 0);
        tapButton(BA);
        tapButton(BRGT);
        checkOutput("op_right", 32'(sel_sub), 1);
        sum  = 5'd7;
        cout = 1'b0;
        diff = 5'b11101;
        applyStimulus(BA);
        checkOutput("sub_calc", 32'(state_o), S_CALC);
        applyStimulus(7'b0);
        applyStimulus(7'b0);
        checkOutput("sub_show", 32'(state_o), S_SHOW);
        checkOutput("sub_disp", 32'(disp_val), 29);
        checkOutput("sub_led", 32'(led), 1);
        checkOutput("sub_sel", 32'(sel_sub), 1);

        // Priority: A beats up in the same frame.
        tapButton(BA);
        tapButton(BA | BUP);
        checkOutput("prio_state", 32'(state_o), S_B);
        checkOutput("prio_op_a", 32'(op_a), 2);

        // Reset during the first CALC cycle.
        tapButton(BA);
        applyStimulus(BA);
        checkOutput("mid_calc", 32'(state_o), S_CALC);
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("mrst_state", 32'(state_o), S_A);
        checkOutput("mrst_op_a", 32'(op_a), 0);
        checkOutput("mrst_op_b", 32'(op_b), 0);
        checkOutput("mrst_sel", 32'(sel_sub), 0);
        checkOutput("mrst_disp", 32'(disp_val), 0);
        checkOutput("mrst_led", 32'(led), 0);
        applyStimulus(BUP);
        checkOutput("rst_beats_valid", 32'(op_a), 0);
        reset_n = 1'b1;
        applyStimulus(7'b0);
        tapButton(BUP);
        checkOutput("post_rst_inc", 32'(op_a), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Controller that turns decoded NES-pad button frames into a sequenced calculator session over the shared `add_sub`/`mux2`/`sevenseg` datapath. Sits between the NES reader and the arithmetic datapath:
- owns operands `a`, `b`, carry-in and the sum/difference select;
- waits for the adder to settle, then latches the result;
- drives the value shown on the seven-segment display and the overflow LED.

## Interface
Parameters:
- `WIDTH`, 4, operand width; datapath results are `WIDTH+1` bits
- `SETTLE`, 2, cycles held in CALC before latching the result (≥1)
- `REPEAT_FRAMES`, 30, frames an up/down button must be held before auto-repeat, then one step per further frame (≥2)

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  reset, synchronous, active-low
- `btn_valid`  in  1  one-cycle pulse: a new NES frame is present on the button inputs
- `up, down, left, right, select, a_but, b_but`  in  1 each  decoded buttons, active-high, sampled only when `btn_valid`=1
- `sum`  in  WIDTH+1  adder output
- `diff`  in  WIDTH+1  subtractor output
- `cout`  in  1  adder carry-out
- `op_a`, `op_b`  out  WIDTH  operands to `add_sub`
- `cin`  out  1  carry-in to `add_sub`
- `sel_sub`  out  1  mux select: 0 = sum, 1 = diff
- `disp_val`  out  WIDTH+1  value to `sevenseg`
- `led`  out  1  overflow/borrow flag of the last result
- `state_o`  out  3  current state encoding (debug)

## Operation
- **Press detection:**
  - A press is button=1 in the current frame and 0 in the previous frame.
  - The previous-frame register updates only on `btn_valid`.
- **Auto-repeat (up/down only):** a held button produces a further press on frame `REPEAT_FRAMES` and on every frame after that. The repeat count clears on release.
- **One action per frame.** Priority: `a_but` > `b_but` > `up` > `down` > `left` > `right` > `select`. Lower-priority presses in the same frame are discarded.
- **States:**
  - **ENTER_A:**
    - up: `op_a`+1 mod 2^WIDTH; down: `op_a`−1 mod 2^WIDTH.
    - `a_but` → ENTER_B.
    - `disp_val`={0,`op_a`}.
  - **ENTER_B:**
    - up/down adjust `op_b` the same way.
    - `select` toggles `cin`.
    - `a_but` → CHOOSE_OP; `b_but` → ENTER_A.
    - `disp_val`={0,`op_b`}.
  - **CHOOSE_OP:**
    - left: `sel_sub`=0; right: `sel_sub`=1; `select` toggles `sel_sub`.
    - `a_but` → CALC; `b_but` → ENTER_B.
    - `disp_val` holds its previous value.
  - **CALC:**
    - Button frames are ignored.
    - After `SETTLE` cycles: result = `sel_sub` ? `diff` : `sum`.
    - `led` = `sel_sub` ? `diff[WIDTH]` : `cout`.
    - `disp_val` = result. → SHOW.
  - **SHOW:**
    - `a_but` → ENTER_A; operands are kept.
    - `b_but` → CHOOSE_OP.
    - `led` and `disp_val` hold until the next CALC completes.
- **Arithmetic:** all operand steps wrap silently. No saturation.
- `op_a`, `op_b`, `cin` and `sel_sub` are stable throughout CALC.

## Timing
- All outputs are registered.
- **Reset values:** state ENTER_A, `op_a`=`op_b`=0, `cin`=0, `sel_sub`=0, `disp_val`=0, `led`=0, repeat counter 0, previous-frame register all 0.
- **Reset priority:** reset wins over any simultaneous `btn_valid`. Reset during CALC abandons the latch; no partial result is visible.
- **Action latency:** the effect of a press appears on outputs in the cycle after the `btn_valid` cycle.
- **CALC latency:** the state enters CALC at cycle N. `disp_val`/`led` update and the state is SHOW at cycle N+`SETTLE`.
- **Back-to-back `btn_valid`** (every cycle) must be handled with no lost frames.
- A `btn_valid` arriving during CALC still updates the previous-frame register, so a button held through CALC is not seen as a new press.
- Wrap boundaries: 15 + up → 0 and 0 + down → 15 (WIDTH=4), on a single frame.

## Structure
- **Package `calc_pkg`:** state enum (ENTER_A, ENTER_B, CHOOSE_OP, CALC, SHOW, 3-bit encoding) and action enum (NONE, UP, DOWN, LEFT, RIGHT, SELECT, A, B).
- **Sub-module `nes_btn_edge`:**
  - Previous-frame register, press detection, up/down auto-repeat counter, priority encoder.
  - Outputs one action enum plus a valid strobe per frame.
- **Top level:** FSM, operand/flag registers, SETTLE counter.

## Test plan
- **Reset and increment:** reset, then 3 frames with `up` pressed and released → `op_a`=3, `disp_val`=3, state ENTER_A, `led`=0.
- **Addition with carry:** `op_a`=9, `op_b`=8, add, `a_but` into CALC with `sum`=17, `cout`=1 → after SETTLE cycles `disp_val`=17, `led`=1, state SHOW.
- **Subtraction with borrow:** `op_a`=2, `op_b`=5, right, `a_but` with `diff`=5'b11101 → `disp_val`=29, `led`=1.
- **Wrap and auto-repeat:**
  - `down` at `op_a`=0 → 15.
  - `up` held for 32 frames from 0 → 1 on press, then repeats at frames 30, 31, 32 → final `op_a`=4.
- **Priority, CALC isolation, mid-CALC reset:**
  - `a_but`+`up` in one frame in ENTER_A → ENTER_B, `op_a` unchanged.
  - Frames arriving during CALC are ignored.
  - `reset_n`=0 in CALC cycle 1 → all outputs return to reset values the next cycle.
